// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// Carries opcode/status into the controller and strobes, mux selects and debug state out.
// master: controller side (drives strobes); slave: datapath side (drives op/zero/mem_ready).
interface multicycle_control_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       memread;
  logic       adrsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic [1:0] immsrc;
  logic [1:0] aluop;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output pcwrite, irwrite, regwrite, memwrite, memread, adrsrc,
           alusrca, alusrcb, resultsrc, immsrc, aluop, illegal, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  pcwrite, irwrite, regwrite, memwrite, memread, adrsrc,
           alusrca, alusrcb, resultsrc, immsrc, aluop, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller: Moore FSM sequencing fetch/decode/execute/writeback.
// Latency: one state per cycle; R/I/store/JAL 4 cycles, load 5, BEQ 3, plus one per mem_ready=0 wait.
// Backpressure: mem_ready=0 holds FETCH, MEMREAD and MEMWRITE with their strobes asserted.
// Ports: clk, reset (sync, active-high); ctl (master modport) carries op/zero/mem_ready in and
//        pcwrite/irwrite/regwrite/memwrite/memread/adrsrc, mux selects, aluop, illegal, state out.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        ctl
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  // Pure state-decoded controls; the input-gated strobes are added at the output.
  typedef struct packed {
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctl_t;

  function automatic ctl_t decode(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      S_DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
      end
      S_MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        c.adrsrc  = 1'b1;
        c.memread = 1'b1;
      end
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTER: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b10;
      end
      S_EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b10;
      end
      S_ALUWB: c.regwrite = 1'b1;
      S_BEQ: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b01;
      end
      S_JAL: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b10;
        c.pcwrite = 1'b1;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctl_t   ctl_q, ctl_d;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = ctl.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctl.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      // op is the held instruction, so only load/store reach here; anything else aborts.
      S_MEMADR: begin
        if (ctl.op == OP_LOAD)       state_d = S_MEMREAD;
        else if (ctl.op == OP_STORE) state_d = S_MEMWRITE;
        else                         state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = ctl.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = ctl.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Controls are registered alongside the state they belong to, so they remain a
  // function of the current state only.
  assign ctl_d = decode(state_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctl_q   <= decode(S_FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  logic in_fetch;
  logic in_beq;
  assign in_fetch = (state_q == S_FETCH);
  assign in_beq   = (state_q == S_BEQ);

  // Write/read strobes are masked during reset so nothing is committed mid-abort.
  assign ctl.pcwrite  = ~reset & ((in_fetch & ctl.mem_ready) | (in_beq & ctl.zero) | ctl_q.pcwrite);
  assign ctl.irwrite  = ~reset & in_fetch & ctl.mem_ready;
  assign ctl.regwrite = ~reset & ctl_q.regwrite;
  assign ctl.memwrite = ~reset & ctl_q.memwrite;
  assign ctl.memread  = ~reset & ctl_q.memread;
  assign ctl.illegal  = ~reset & ctl_q.illegal;

  assign ctl.adrsrc    = ctl_q.adrsrc;
  assign ctl.alusrca   = ctl_q.alusrca;
  assign ctl.alusrcb   = ctl_q.alusrcb;
  assign ctl.resultsrc = ctl_q.resultsrc;
  assign ctl.aluop     = ctl_q.aluop;
  assign ctl.state     = state_q;

  always_comb begin
    case (ctl.op)
      OP_STORE: ctl.immsrc = 2'b01;
      OP_BEQ:   ctl.immsrc = 2'b10;
      OP_JAL:   ctl.immsrc = 2'b11;
      default:  ctl.immsrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus reset/trap sequences.
module tb_multicycle_control;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, mrd, adr;
    logic [1:0] asa, asb, rs, imm, aop;
    logic       ill;
  } out_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       z;
    logic       mr;
    out_t       exp;
  } vec_t;

  logic clk;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   errors;
  vec_t tbl[$];

  function automatic vec_t r(input logic rst, input logic [6:0] op, input logic z, input logic mr,
                             input logic [3:0] st, input logic pcw, input logic irw, input logic rw,
                             input logic mw, input logic mrd, input logic adr,
                             input logic [1:0] asa, input logic [1:0] asb, input logic [1:0] rs,
                             input logic [1:0] imm, input logic [1:0] aop, input logic ill);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.mr = mr;
    v.exp = '{st, pcw, irw, rw, mw, mrd, adr, asa, asb, rs, imm, aop, ill};
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{bus.state, bus.pcwrite, bus.irwrite, bus.regwrite, bus.memwrite, bus.memread,
          bus.adrsrc, bus.alusrca, bus.alusrcb, bus.resultsrc, bus.immsrc, bus.aluop,
          bus.illegal};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    out_t act;
    int   ill_cnt;
    int   wr_cnt;
    bit   found;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.op = R;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // rst op z mr | st pcw irw rw mw mrd adr asa asb rs imm aop ill
    tbl.push_back(r(1, R,  0, 1,  0, 0,0,0,0,0,0, 0,2,2,0,0, 0)); // in reset: strobes forced off
    tbl.push_back(r(0, R,  0, 1,  0, 1,1,0,0,1,0, 0,2,2,0,0, 0)); // R-type
    tbl.push_back(r(0, R,  0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,0, 0));
    tbl.push_back(r(0, R,  0, 1,  6, 0,0,0,0,0,0, 2,0,0,0,2, 0));
    tbl.push_back(r(0, R,  0, 1,  8, 0,0,1,0,0,0, 0,0,0,0,0, 0));
    tbl.push_back(r(0, LD, 0, 1,  0, 1,1,0,0,1,0, 0,2,2,0,0, 0)); // load, two waits
    tbl.push_back(r(0, LD, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,0, 0));
    tbl.push_back(r(0, LD, 0, 1,  2, 0,0,0,0,0,0, 2,1,0,0,0, 0));
    tbl.push_back(r(0, LD, 0, 0,  3, 0,0,0,0,1,1, 0,0,0,0,0, 0));
    tbl.push_back(r(0, LD, 0, 0,  3, 0,0,0,0,1,1, 0,0,0,0,0, 0));
    tbl.push_back(r(0, LD, 0, 1,  3, 0,0,0,0,1,1, 0,0,0,0,0, 0));
    tbl.push_back(r(0, LD, 0, 1,  4, 0,0,1,0,0,0, 0,0,1,0,0, 0));
    tbl.push_back(r(0, ST, 0, 0,  0, 0,0,0,0,1,0, 0,2,2,1,0, 0)); // fetch wait, then store wait
    tbl.push_back(r(0, ST, 0, 1,  0, 1,1,0,0,1,0, 0,2,2,1,0, 0));
    tbl.push_back(r(0, ST, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,1,0, 0));
    tbl.push_back(r(0, ST, 0, 1,  2, 0,0,0,0,0,0, 2,1,0,1,0, 0));
    tbl.push_back(r(0, ST, 0, 0,  5, 0,0,0,1,0,1, 0,0,0,1,0, 0));
    tbl.push_back(r(0, ST, 0, 1,  5, 0,0,0,1,0,1, 0,0,0,1,0, 0));
    tbl.push_back(r(0, BR, 1, 1,  0, 1,1,0,0,1,0, 0,2,2,2,0, 0)); // BEQ taken
    tbl.push_back(r(0, BR, 1, 1,  1, 0,0,0,0,0,0, 1,1,0,2,0, 0));
    tbl.push_back(r(0, BR, 1, 1,  9, 1,0,0,0,0,0, 2,0,0,2,1, 0));
    tbl.push_back(r(0, BR, 0, 1,  0, 1,1,0,0,1,0, 0,2,2,2,0, 0)); // BEQ not taken
    tbl.push_back(r(0, BR, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,2,0, 0));
    tbl.push_back(r(0, BR, 0, 1,  9, 0,0,0,0,0,0, 2,0,0,2,1, 0));
    tbl.push_back(r(0, JL, 0, 1,  0, 1,1,0,0,1,0, 0,2,2,3,0, 0)); // JAL
    tbl.push_back(r(0, JL, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,3,0, 0));
    tbl.push_back(r(0, JL, 0, 1, 10, 1,0,0,0,0,0, 1,2,0,3,0, 0));
    tbl.push_back(r(0, JL, 0, 1,  8, 0,0,1,0,0,0, 0,0,0,3,0, 0));
    tbl.push_back(r(0, IT, 0, 1,  0, 1,1,0,0,1,0, 0,2,2,0,0, 0)); // I-type ALU
    tbl.push_back(r(0, IT, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,0, 0));
    tbl.push_back(r(0, IT, 0, 1,  7, 0,0,0,0,0,0, 2,1,0,0,2, 0));
    tbl.push_back(r(0, IT, 0, 1,  8, 0,0,1,0,0,0, 0,0,0,0,0, 0));
    tbl.push_back(r(0, BAD,0, 1,  0, 1,1,0,0,1,0, 0,2,2,0,0, 0)); // illegal opcode
    tbl.push_back(r(0, BAD,0, 1,  1, 0,0,0,0,0,0, 1,1,0,0,0, 0));
    tbl.push_back(r(0, BAD,0, 1, 11, 0,0,0,0,0,0, 0,0,0,0,0, 1));
    tbl.push_back(r(0, R,  0, 0,  0, 0,0,0,0,1,0, 0,2,2,0,0, 0));
    tbl.push_back(r(0, ST, 0, 1,  0, 1,1,0,0,1,0, 0,2,2,1,0, 0)); // reset during MEMWRITE
    tbl.push_back(r(0, ST, 0, 1,  1, 0,0,0,0,0,0, 1,1,0,1,0, 0));
    tbl.push_back(r(0, ST, 0, 1,  2, 0,0,0,0,0,0, 2,1,0,1,0, 0));
    tbl.push_back(r(1, ST, 0, 0,  5, 0,0,0,0,0,1, 0,0,0,1,0, 0));
    tbl.push_back(r(0, ST, 0, 0,  0, 0,0,0,0,1,0, 0,2,2,1,0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      reset         = tbl[i].rst;
      bus.op        = tbl[i].op;
      bus.zero      = tbl[i].z;
      bus.mem_ready = tbl[i].mr;
      #1;
      act = sample();
      checks++;
      if (act !== tbl[i].exp) begin
        errors++;
        $display("FAIL vec%0d actual=%h expected=%h", i, act, tbl[i].exp);
      end
    end

    // Reset while stalled in MEMREAD.
    @(negedge clk);
    bus.op = LD;
    bus.mem_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.state == 4'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_memread", {31'd0, found}, 32'd1);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("memread_masked_in_reset", {31'd0, bus.memread}, 32'd0);
    check("state_held_until_edge", {28'd0, bus.state}, 32'd3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("state_after_reset", {28'd0, bus.state}, 32'd0);
    check("memread_after_reset", {31'd0, bus.memread}, 32'd1);

    // Illegal opcode from FETCH: exactly one pulse, no writes outside fetch.
    bus.op = BAD;
    bus.zero = 1'b1;
    bus.mem_ready = 1'b1;
    ill_cnt = 0;
    wr_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.illegal) ill_cnt++;
      if (bus.regwrite || bus.memwrite || (bus.state != 4'd0 && (bus.pcwrite || bus.irwrite)))
        wr_cnt++;
      @(negedge clk);
    end
    #1;
    check("illegal_pulse_count", ill_cnt, 32'd1);
    check("trap_write_count", wr_cnt, 32'd0);
    check("state_after_trap", {28'd0, bus.state}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; returns FSM to FETCH.
REQ-004 op  input  7  opcode from instruction register (instr[6:0]).
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes current access this cycle.
REQ-007 pcwrite, irwrite, regwrite, memwrite, memread, adrsrc  output  1 each  PC/IR/regfile/memory write, memory read strobe, address select (0=PC, 1=ALUOut).
REQ-008 alusrca, alusrcb, resultsrc, immsrc  output  2 each  ALU A-mux (00 PC, 01 oldPC, 10 rs1); ALU B-mux (00 rs2, 01 imm, 10 const 4); result mux (00 ALUOut, 01 mem data, 10 ALU result); immediate format (00 I, 01 S, 10 B, 11 J).
REQ-009 aluop  output  2  to ALU control: 00 add, 01 subtract, 10 funct-decoded.
REQ-010 illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-011 state  output  4  current state encoding (debug/verification).

Function
REQ-012 SHALL be a Moore FSM; outputs are functions of state only, except pcwrite/irwrite (gated by mem_ready in FETCH), pcwrite in BEQ (gated by zero), and immsrc (decoded from op).
REQ-013 State encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11; codes 12-15 SHALL go to FETCH next cycle with all enables 0.
REQ-014 Defaults in every state: all 1-bit enables 0, all 2-bit selects 00, unless listed below.
REQ-015 FETCH: memread=1, alusrcb=10, resultsrc=10; irwrite=pcwrite=mem_ready; stay while mem_ready=0, else -> DECODE.
REQ-016 DECODE: alusrca=01, alusrcb=01 (branch target); next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL, any other -> TRAP.
REQ-017 MEMADR: alusrca=10, alusrcb=01; op 0000011 -> MEMREAD, 0100011 -> MEMWRITE.
REQ-018 MEMREAD: adrsrc=1, memread=1; stay until mem_ready=1, then -> MEMWB.
REQ-019 MEMWB: resultsrc=01, regwrite=1; -> FETCH.
REQ-020 MEMWRITE: adrsrc=1, memwrite=1 held every cycle until mem_ready=1; then -> FETCH.
REQ-021 EXECUTER: alusrca=10, aluop=10; -> ALUWB. EXECUTEI: alusrca=10, alusrcb=01, aluop=10; -> ALUWB.
REQ-022 ALUWB: regwrite=1; -> FETCH.
REQ-023 BEQ: alusrca=10, aluop=01, pcwrite=zero; -> FETCH.
REQ-024 JAL: alusrca=01, alusrcb=10, pcwrite=1; -> ALUWB (writes PC+4 to rd).
REQ-025 TRAP: illegal=1 for exactly one cycle, no write enables; -> FETCH.
REQ-026 immsrc SHALL be 01 for op 0100011, 10 for 1100011, 11 for 1101111, 00 otherwise.
REQ-027 Latency (mem_ready=1 throughout): R/I-ALU 4 cycles, load 5, store 4, BEQ 3, JAL 4; each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.

Reset
REQ-028 reset=1 at a rising edge SHALL load state FETCH regardless of current state, including mid-wait in MEMREAD/MEMWRITE.
REQ-029 While reset=1, pcwrite, irwrite, regwrite, memwrite, memread and illegal SHALL be forced 0.
REQ-030 After reset deasserts, first output cycle SHALL be FETCH with memread=1.

Verification
REQ-031 R-type: op=0110011, mem_ready=1 -> states 0,1,6,8,0; aluop=10 in state 6; regwrite=1 only in state 8.
REQ-032 Load with wait: op=0000011, mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; adrsrc=1 in 3; regwrite with resultsrc=01 in 4.
REQ-033 BEQ: op=1100011, zero=1 -> pcwrite=1 in state 9, aluop=01; repeat zero=0 -> pcwrite=0.
REQ-034 Store: op=0100011, mem_ready=0 one cycle in MEMWRITE -> memwrite=1 for 2 cycles, immsrc=01, then FETCH.
REQ-035 Illegal: op=1111111 -> states 0,1,11,0; illegal=1 exactly one cycle; no write enable asserted.
REQ-036 Reset mid-op: reset=1 while in MEMWRITE -> memwrite=0 that cycle; state=0 next cycle.
